// File: rtl/rs_br_pkg.sv
// ============================================================================
// Module      : rs_br_pkg
// Description : Shared widths and the buffered branch-op payload type for the
//               branch reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_br_pkg;

  localparam int ALU_OP_SEL      = 4;
  localparam int RV32_DATA_WIDTH = 32;
  localparam int RV32_PC_WIDTH   = 32;
  localparam int BR_RS_ENT_NUM   = 4;
  localparam int BR_RS_ENT_SEL   = $clog2(BR_RS_ENT_NUM);

  // Fields that travel untouched from dispatch to issue.
  typedef struct packed {
    logic                       is_jal;
    logic                       is_jalr;
    logic [ALU_OP_SEL-1:0]      alu_op;
    logic [RV32_PC_WIDTH-1:0]   pc;
    logic [RV32_DATA_WIDTH-1:0] imm;
    logic [RV32_PC_WIDTH-1:0]   pred_jmpaddr;
  } br_payload_t;

endpackage

`default_nettype wire

// File: rtl/rs_br_select.sv
// ============================================================================
// Module      : rs_br_select
// Description : Combinational issue picker: one-hot grant over the ready
//               vector. Oldest-first when BR_RS_AGE_ORDER_EN is defined,
//               lowest-index otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_br_select
  import rs_br_pkg::*;
#(
  parameter int ENTRY_NUM = BR_RS_ENT_NUM
) (
  input  logic [ENTRY_NUM-1:0]       ready,
`ifdef BR_RS_AGE_ORDER_EN
  input  logic [ENTRY_NUM*((ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1)-1:0] age,
`endif
  output logic [ENTRY_NUM-1:0]       grant,
  output logic                       found
);

`ifdef BR_RS_AGE_ORDER_EN
  localparam int AGE_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  // Ranks of valid entries are unique, so exactly one ready entry survives.
  always_comb begin
    grant = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < ENTRY_NUM; j++) begin
        if (ready[j] && (age[j*AGE_W +: AGE_W] < age[i*AGE_W +: AGE_W]))
          grant[i] = 1'b0;
      end
    end
    found = |ready;
  end
`else
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/rs_br.sv
// ============================================================================
// Module      : rs_br
// Description : Branch-unit reservation station: buffers dispatched ops,
//               wakes operands from the CDB, issues one ready op per cycle.
//               Optional macro BR_RS_AGE_ORDER_EN selects oldest-first issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_br
  import rs_br_pkg::*;
#(
  parameter int ENTRY_NUM = BR_RS_ENT_NUM,
  parameter int TAG_W     = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_dp_vld,
  output logic                               o_dp_rdy,
  input  logic                               i_dp_is_jal,
  input  logic                               i_dp_is_jalr,
  input  logic [ALU_OP_SEL-1:0]              i_dp_alu_op,
  input  logic [RV32_PC_WIDTH-1:0]           i_dp_pc,
  input  logic [RV32_PC_WIDTH-1:0]           i_dp_pred_jmpaddr,
  input  logic [RV32_DATA_WIDTH-1:0]         i_dp_imm,
  input  logic                               i_dp_rs1_rdy,
  input  logic                               i_dp_rs2_rdy,
  input  logic [RV32_DATA_WIDTH-1:0]         i_dp_rs1,
  input  logic [RV32_DATA_WIDTH-1:0]         i_dp_rs2,
  input  logic [TAG_W-1:0]                   i_dp_rs1_tag,
  input  logic [TAG_W-1:0]                   i_dp_rs2_tag,
  input  logic [TAG_W-1:0]                   i_dp_rob_tag,
  input  logic                               i_cdb_vld,
  input  logic [TAG_W-1:0]                   i_cdb_tag,
  input  logic [RV32_DATA_WIDTH-1:0]         i_cdb_data,
  input  logic                               i_flush,
  input  logic                               i_ex_accessable,
  output logic                               o_is_vld,
  output logic                               o_is_is_jal,
  output logic                               o_is_is_jalr,
  output logic [ALU_OP_SEL-1:0]              o_is_alu_op,
  output logic [RV32_DATA_WIDTH-1:0]         o_is_rs1,
  output logic [RV32_DATA_WIDTH-1:0]         o_is_rs2,
  output logic [RV32_PC_WIDTH-1:0]           o_is_pc,
  output logic [RV32_DATA_WIDTH-1:0]         o_is_imm,
  output logic [RV32_PC_WIDTH-1:0]           o_is_pred_jmpaddr,
  output logic [TAG_W-1:0]                   o_is_rob_tag,
  output logic [$clog2(ENTRY_NUM+1)-1:0]     o_occupancy
);

  localparam int OCC_W = $clog2(ENTRY_NUM+1);

  logic [ENTRY_NUM-1:0]       r_valid;
  logic [ENTRY_NUM-1:0]       r_rs1_rdy;
  logic [ENTRY_NUM-1:0]       r_rs2_rdy;
  logic [RV32_DATA_WIDTH-1:0] r_rs1     [ENTRY_NUM];
  logic [RV32_DATA_WIDTH-1:0] r_rs2     [ENTRY_NUM];
  logic [TAG_W-1:0]           r_rs1_tag [ENTRY_NUM];
  logic [TAG_W-1:0]           r_rs2_tag [ENTRY_NUM];
  logic [TAG_W-1:0]           r_rob_tag [ENTRY_NUM];
  br_payload_t                r_pl      [ENTRY_NUM];

  logic                       r_is_vld;
  br_payload_t                r_is_pl;
  logic [RV32_DATA_WIDTH-1:0] r_is_rs1;
  logic [RV32_DATA_WIDTH-1:0] r_is_rs2;
  logic [TAG_W-1:0]           r_is_rob_tag;

  logic [ENTRY_NUM-1:0]       w_ready;
  logic [ENTRY_NUM-1:0]       w_grant;
  logic                       w_found;
  logic [ENTRY_NUM-1:0]       w_free_oh;
  logic                       w_free_any;
  logic [OCC_W-1:0]           w_occ;
  logic                       w_dp_go;
  logic                       w_is_go;
  logic                       w_dp_rs1_hit;
  logic                       w_dp_rs2_hit;
  logic [ENTRY_NUM-1:0]       w_wake1;
  logic [ENTRY_NUM-1:0]       w_wake2;
  br_payload_t                w_dp_pl;
  br_payload_t                w_sel_pl;
  logic [RV32_DATA_WIDTH-1:0] w_sel_rs1;
  logic [RV32_DATA_WIDTH-1:0] w_sel_rs2;
  logic [TAG_W-1:0]           w_sel_rob_tag;

`ifdef BR_RS_AGE_ORDER_EN
  localparam int AGE_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  logic [AGE_W-1:0]           r_age [ENTRY_NUM];
  logic [ENTRY_NUM*AGE_W-1:0] w_age_flat;
  logic [AGE_W-1:0]           w_is_age;
  logic [AGE_W-1:0]           w_new_age;
`endif

  always_comb begin
    w_occ      = '0;
    w_free_oh  = '0;
    w_free_any = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
      if (!r_valid[i] && !w_free_any) begin
        w_free_oh[i] = 1'b1;
        w_free_any   = 1'b1;
      end
    end
  end

  assign o_dp_rdy    = (w_occ < OCC_W'(ENTRY_NUM));
  assign o_occupancy = w_occ;
  assign w_ready     = r_valid & r_rs1_rdy & r_rs2_rdy;
  assign w_dp_go     = i_dp_vld & o_dp_rdy & ~i_flush;
  assign w_is_go     = i_ex_accessable & w_found & ~i_flush;

  assign w_dp_rs1_hit = ~i_dp_rs1_rdy & i_cdb_vld & (i_cdb_tag == i_dp_rs1_tag);
  assign w_dp_rs2_hit = ~i_dp_rs2_rdy & i_cdb_vld & (i_cdb_tag == i_dp_rs2_tag);

  assign w_dp_pl = '{is_jal: i_dp_is_jal, is_jalr: i_dp_is_jalr, alu_op: i_dp_alu_op,
                     pc: i_dp_pc, imm: i_dp_imm, pred_jmpaddr: i_dp_pred_jmpaddr};

  always_comb begin
    w_wake1       = '0;
    w_wake2       = '0;
    w_sel_pl      = '0;
    w_sel_rs1     = '0;
    w_sel_rs2     = '0;
    w_sel_rob_tag = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_wake1[i] = r_valid[i] & ~r_rs1_rdy[i] & i_cdb_vld & (i_cdb_tag == r_rs1_tag[i]);
      w_wake2[i] = r_valid[i] & ~r_rs2_rdy[i] & i_cdb_vld & (i_cdb_tag == r_rs2_tag[i]);
      if (w_grant[i]) begin
        w_sel_pl      = r_pl[i];
        w_sel_rs1     = r_rs1[i];
        w_sel_rs2     = r_rs2[i];
        w_sel_rob_tag = r_rob_tag[i];
      end
    end
  end

`ifdef BR_RS_AGE_ORDER_EN
  // Rank = number of older valid entries; rank 0 is the oldest.
  always_comb begin
    w_age_flat = '0;
    w_is_age   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_age_flat[i*AGE_W +: AGE_W] = r_age[i];
      if (w_grant[i]) w_is_age = r_age[i];
    end
    w_new_age = AGE_W'(w_occ - OCC_W'(w_is_go));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) r_age[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (w_dp_go && w_free_oh[i])
          r_age[i] <= w_new_age;
        else if (w_is_go && r_valid[i] && (r_age[i] > w_is_age))
          r_age[i] <= r_age[i] - 1'b1;
      end
    end
  end
`endif

  rs_br_select #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_select (
    .ready (w_ready),
`ifdef BR_RS_AGE_ORDER_EN
    .age   (w_age_flat),
`endif
    .grant (w_grant),
    .found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_rs1_rdy <= '0;
      r_rs2_rdy <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_rs1[i]     <= '0;
        r_rs2[i]     <= '0;
        r_rs1_tag[i] <= '0;
        r_rs2_tag[i] <= '0;
        r_rob_tag[i] <= '0;
        r_pl[i]      <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (w_dp_go && w_free_oh[i]) begin
          r_valid[i]   <= 1'b1;
          r_rs1_rdy[i] <= i_dp_rs1_rdy | w_dp_rs1_hit;
          r_rs2_rdy[i] <= i_dp_rs2_rdy | w_dp_rs2_hit;
          r_rs1[i]     <= w_dp_rs1_hit ? i_cdb_data : i_dp_rs1;
          r_rs2[i]     <= w_dp_rs2_hit ? i_cdb_data : i_dp_rs2;
          r_rs1_tag[i] <= i_dp_rs1_tag;
          r_rs2_tag[i] <= i_dp_rs2_tag;
          r_rob_tag[i] <= i_dp_rob_tag;
          r_pl[i]      <= w_dp_pl;
        end else begin
          if (w_is_go && w_grant[i]) r_valid[i] <= 1'b0;
          if (w_wake1[i]) begin
            r_rs1[i]     <= i_cdb_data;
            r_rs1_rdy[i] <= 1'b1;
          end
          if (w_wake2[i]) begin
            r_rs2[i]     <= i_cdb_data;
            r_rs2_rdy[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_vld     <= 1'b0;
      r_is_pl      <= '0;
      r_is_rs1     <= '0;
      r_is_rs2     <= '0;
      r_is_rob_tag <= '0;
    end else begin
      r_is_vld <= w_is_go;
      if (w_is_go) begin
        r_is_pl      <= w_sel_pl;
        r_is_rs1     <= w_sel_rs1;
        r_is_rs2     <= w_sel_rs2;
        r_is_rob_tag <= w_sel_rob_tag;
      end
    end
  end

  assign o_is_vld          = r_is_vld;
  assign o_is_is_jal       = r_is_pl.is_jal;
  assign o_is_is_jalr      = r_is_pl.is_jalr;
  assign o_is_alu_op       = r_is_pl.alu_op;
  assign o_is_pc           = r_is_pl.pc;
  assign o_is_imm          = r_is_pl.imm;
  assign o_is_pred_jmpaddr = r_is_pl.pred_jmpaddr;
  assign o_is_rs1          = r_is_rs1;
  assign o_is_rs2          = r_is_rs2;
  assign o_is_rob_tag      = r_is_rob_tag;

endmodule

`default_nettype wire

// File: tb/tb_rs_br.sv
// ============================================================================
// Module      : tb_rs_br
// Description : Scoreboard bench for rs_br; issue order follows
//               BR_RS_AGE_ORDER_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_br;
  import rs_br_pkg::*;

  localparam int TAG_W = 6;

  typedef struct packed {
    logic [5:0]  rob;
    logic        jal;
    logic        jalr;
    logic [3:0]  alu;
    logic [31:0] pc;
    logic [31:0] pred;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_dp_vld, o_dp_rdy, i_dp_is_jal, i_dp_is_jalr;
  logic [3:0]  i_dp_alu_op;
  logic [31:0] i_dp_pc, i_dp_pred_jmpaddr, i_dp_imm, i_dp_rs1, i_dp_rs2;
  logic        i_dp_rs1_rdy, i_dp_rs2_rdy;
  logic [5:0]  i_dp_rs1_tag, i_dp_rs2_tag, i_dp_rob_tag;
  logic        i_cdb_vld;
  logic [5:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        i_flush, i_ex_accessable;
  logic        o_is_vld, o_is_is_jal, o_is_is_jalr;
  logic [3:0]  o_is_alu_op;
  logic [31:0] o_is_rs1, o_is_rs2, o_is_pc, o_is_imm, o_is_pred_jmpaddr;
  logic [5:0]  o_is_rob_tag;
  logic [2:0]  o_occupancy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  rs_br #(.ENTRY_NUM(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dp_vld(i_dp_vld), .o_dp_rdy(o_dp_rdy),
    .i_dp_is_jal(i_dp_is_jal), .i_dp_is_jalr(i_dp_is_jalr), .i_dp_alu_op(i_dp_alu_op),
    .i_dp_pc(i_dp_pc), .i_dp_pred_jmpaddr(i_dp_pred_jmpaddr), .i_dp_imm(i_dp_imm),
    .i_dp_rs1_rdy(i_dp_rs1_rdy), .i_dp_rs2_rdy(i_dp_rs2_rdy),
    .i_dp_rs1(i_dp_rs1), .i_dp_rs2(i_dp_rs2),
    .i_dp_rs1_tag(i_dp_rs1_tag), .i_dp_rs2_tag(i_dp_rs2_tag), .i_dp_rob_tag(i_dp_rob_tag),
    .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .i_flush(i_flush), .i_ex_accessable(i_ex_accessable),
    .o_is_vld(o_is_vld), .o_is_is_jal(o_is_is_jal), .o_is_is_jalr(o_is_is_jalr),
    .o_is_alu_op(o_is_alu_op), .o_is_rs1(o_is_rs1), .o_is_rs2(o_is_rs2),
    .o_is_pc(o_is_pc), .o_is_imm(o_is_imm), .o_is_pred_jmpaddr(o_is_pred_jmpaddr),
    .o_is_rob_tag(o_is_rob_tag), .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [5:0] rob, input logic jal, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    e.rob  = rob;
    e.jal  = jal;
    e.jalr = 1'b0;
    e.alu  = pc[7:4];
    e.pc   = pc;
    e.pred = pc + 32'h20;
    e.imm  = pc + 32'h10;
    e.rs1  = rs1;
    e.rs2  = rs2;
    return e;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // One dispatch cycle; operand values not ready are driven as junk.
  task automatic dp(input exp_t e, input logic r1, input logic [5:0] t1,
                    input logic r2, input logic [5:0] t2);
    i_dp_vld          = 1'b1;
    i_dp_is_jal       = e.jal;
    i_dp_is_jalr      = e.jalr;
    i_dp_alu_op       = e.alu;
    i_dp_pc           = e.pc;
    i_dp_pred_jmpaddr = e.pred;
    i_dp_imm          = e.imm;
    i_dp_rob_tag      = e.rob;
    i_dp_rs1_rdy      = r1;
    i_dp_rs1_tag      = t1;
    i_dp_rs1          = r1 ? e.rs1 : 32'hDEAD_0001;
    i_dp_rs2_rdy      = r2;
    i_dp_rs2_tag      = t2;
    i_dp_rs2          = r2 ? e.rs2 : 32'hDEAD_0002;
    cyc();
    i_dp_vld          = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    i_cdb_vld  = 1'b1;
    i_cdb_tag  = tag;
    i_cdb_data = data;
    cyc();
    i_cdb_vld  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_is_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got rob_tag %h expected no issue", o_is_rob_tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("is_rob_tag", {26'd0, o_is_rob_tag}, {26'd0, mon_e.rob});
        chk("is_pc", o_is_pc, mon_e.pc);
        chk("is_rs1", o_is_rs1, mon_e.rs1);
        chk("is_rs2", o_is_rs2, mon_e.rs2);
        chk("is_ctrl", {26'd0, o_is_is_jal, o_is_is_jalr, o_is_alu_op},
            {26'd0, mon_e.jal, mon_e.jalr, mon_e.alu});
        chk("is_imm", o_is_imm, mon_e.imm);
        chk("is_pred", o_is_pred_jmpaddr, mon_e.pred);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    i_dp_vld = 0; i_dp_is_jal = 0; i_dp_is_jalr = 0; i_dp_alu_op = 0;
    i_dp_pc = 0; i_dp_pred_jmpaddr = 0; i_dp_imm = 0;
    i_dp_rs1_rdy = 0; i_dp_rs2_rdy = 0; i_dp_rs1 = 0; i_dp_rs2 = 0;
    i_dp_rs1_tag = 0; i_dp_rs2_tag = 0; i_dp_rob_tag = 0;
    i_cdb_vld = 0; i_cdb_tag = 0; i_cdb_data = 0;
    i_flush = 0; i_ex_accessable = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;

    chk("rst_is_vld", {31'd0, o_is_vld}, 32'd0);
    chk("rst_occ", {29'd0, o_occupancy}, 32'd0);
    chk("rst_dp_rdy", {31'd0, o_dp_rdy}, 32'd1);
    chk("rst_is_pc", o_is_pc, 32'd0);
    cyc();

    // Ready JAL: held one cycle in the station, issued at the following edge.
    e = mk(6'd1, 1'b1, 32'h100, 32'd0, 32'd0);
    exp_q.push_back(e);
    dp(e, 1'b1, 6'd0, 1'b1, 6'd0);
    chk("jal_occ1", {29'd0, o_occupancy}, 32'd1);
    chk("jal_not_yet", {31'd0, o_is_vld}, 32'd0);
    cyc();
    chk("jal_issued", {31'd0, o_is_vld}, 32'd1);
    chk("jal_occ0", {29'd0, o_occupancy}, 32'd0);
    cyc();
    chk("jal_pulse", {31'd0, o_is_vld}, 32'd0);
    chk("jal_payload_held", o_is_pc, 32'h100);

    // BEQ waiting on tag 5.
    e = mk(6'd2, 1'b0, 32'h200, 32'h1234, 32'h55);
    dp(e, 1'b0, 6'd5, 1'b1, 6'd0);
    cyc();
    cyc();
    chk("beq_wait_vld", {31'd0, o_is_vld}, 32'd0);
    chk("beq_wait_occ", {29'd0, o_occupancy}, 32'd1);
    exp_q.push_back(e);
    cdb(6'd5, 32'h1234);
    chk("beq_wake_lat0", {31'd0, o_is_vld}, 32'd0);
    cyc();
    chk("beq_wake_lat1", {31'd0, o_is_vld}, 32'd1);

    // Dispatch-cycle bypass from the CDB.
    e = mk(6'd3, 1'b0, 32'h300, 32'hBEEF, 32'h66);
    exp_q.push_back(e);
    i_cdb_vld = 1'b1; i_cdb_tag = 6'd7; i_cdb_data = 32'hBEEF;
    dp(e, 1'b0, 6'd7, 1'b1, 6'd0);
    i_cdb_vld = 1'b0;
    chk("byp_occ", {29'd0, o_occupancy}, 32'd1);
    cyc();
    chk("byp_issued", {31'd0, o_is_vld}, 32'd1);

    // Both operands wake on the same broadcast.
    e = mk(6'd4, 1'b0, 32'h400, 32'h99, 32'h99);
    dp(e, 1'b0, 6'd9, 1'b0, 6'd9);
    exp_q.push_back(e);
    cdb(6'd9, 32'h99);
    cyc();
    chk("dual_wake", {31'd0, o_is_vld}, 32'd1);
    cyc();

    // Fill all four entries with waiting ops (tags 20..23).
    for (int k = 0; k < 4; k++) begin
      e = mk(6'(10 + k), 1'b0, 32'h1000 + 32'(k * 16), 32'h2000 + 32'(k), 32'h77);
      dp(e, 1'b0, 6'(20 + k), 1'b1, 6'd0);
    end
    chk("full_occ", {29'd0, o_occupancy}, 32'd4);
    chk("full_dp_rdy", {31'd0, o_dp_rdy}, 32'd0);
    e = mk(6'd14, 1'b0, 32'h1400, 32'd1, 32'd2);
    dp(e, 1'b1, 6'd0, 1'b1, 6'd0);
    chk("full_ignored", {29'd0, o_occupancy}, 32'd4);
    exp_q.push_back(mk(6'd12, 1'b0, 32'h1020, 32'hABC2, 32'h77));
    cdb(6'd22, 32'hABC2);
    chk("full_still", {31'd0, o_dp_rdy}, 32'd0);
    cyc();
    chk("freed_issue", {31'd0, o_is_vld}, 32'd1);
    chk("freed_dp_rdy", {31'd0, o_dp_rdy}, 32'd1);
    chk("freed_occ", {29'd0, o_occupancy}, 32'd3);

    // Stall issue; a younger op lands in lower index 2 than waiting rob 13.
    i_ex_accessable = 1'b0;
    e = mk(6'd15, 1'b1, 32'h1500, 32'h5, 32'h6);
    dp(e, 1'b1, 6'd0, 1'b1, 6'd0);
    cdb(6'd23, 32'hABC3);
    for (int k = 0; k < 3; k++) begin
      chk("stall_no_issue", {31'd0, o_is_vld}, 32'd0);
      cyc();
    end
    chk("stall_occ", {29'd0, o_occupancy}, 32'd4);
`ifdef BR_RS_AGE_ORDER_EN
    exp_q.push_back(mk(6'd13, 1'b0, 32'h1030, 32'hABC3, 32'h77));
    exp_q.push_back(mk(6'd15, 1'b1, 32'h1500, 32'h5, 32'h6));
`else
    exp_q.push_back(mk(6'd15, 1'b1, 32'h1500, 32'h5, 32'h6));
    exp_q.push_back(mk(6'd13, 1'b0, 32'h1030, 32'hABC3, 32'h77));
`endif
    i_ex_accessable = 1'b1;
    cyc();
    chk("b2b_first", {31'd0, o_is_vld}, 32'd1);
    cyc();
    chk("b2b_second", {31'd0, o_is_vld}, 32'd1);
    chk("b2b_occ", {29'd0, o_occupancy}, 32'd2);

    // Flush with a simultaneous dispatch while three entries are valid.
    e = mk(6'd16, 1'b0, 32'h1600, 32'd0, 32'd0);
    dp(e, 1'b0, 6'd30, 1'b1, 6'd0);
    chk("pre_flush_occ", {29'd0, o_occupancy}, 32'd3);
    i_flush = 1'b1;
    e = mk(6'd17, 1'b0, 32'h1700, 32'd1, 32'd1);
    dp(e, 1'b1, 6'd0, 1'b1, 6'd0);
    i_flush = 1'b0;
    chk("flush_occ", {29'd0, o_occupancy}, 32'd0);
    chk("flush_vld", {31'd0, o_is_vld}, 32'd0);
    cdb(6'd20, 32'h1);
    cdb(6'd21, 32'h2);
    cdb(6'd30, 32'h3);
    cyc();
    chk("flush_stays_empty", {29'd0, o_occupancy}, 32'd0);

    // Asynchronous reset while an issue pulse is high.
    e = mk(6'd40, 1'b1, 32'h4000, 32'h8, 32'h9);
    exp_q.push_back(e);
    dp(e, 1'b1, 6'd0, 1'b1, 6'd0);
    e = mk(6'd41, 1'b0, 32'h4100, 32'h8, 32'h9);
    dp(e, 1'b0, 6'd33, 1'b1, 6'd0);
    chk("arst_pre_vld", {31'd0, o_is_vld}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, o_is_vld}, 32'd0);
    chk("arst_occ", {29'd0, o_occupancy}, 32'd0);
    chk("arst_pc", o_is_pc, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_idle", {31'd0, o_is_vld}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
